// File: rtl/pc_return_stack.sv
// pc_return_stack
//
// Call/return address stack that drives the program counter's load interface.
// The decode stage raises call, ret or jump. The stack answers in the same
// cycle on load/d, so the PC takes the new value on the next rising edge.
//
// Commands and their effect:
//   CALL : d = target.  At the edge pc_q+1 is pushed.
//   RET  : d = top entry.  At the edge the entry is popped.
//   JUMP : d = target.  The stack is not touched.
// When several commands are raised together, ret wins over call, and call wins
// over jump. Lower-priority commands are dropped.
//
// Ports:
//   clock      system clock, rising edge
//   reset      synchronous active-low reset
//   pc_q       current PC value
//   call       subroutine call this cycle
//   ret        return this cycle
//   jump       unconditional jump this cycle
//   target     call/jump destination
//   load       PC load strobe (combinational)
//   d          next PC value when load=1 (combinational)
//   depth      number of valid entries, 0..DEPTH
//   full       depth == DEPTH
//   empty      depth == 0
//   overflow   sticky: CALL while full
//   underflow  sticky: RET while empty
//   flag_clr   clears overflow/underflow (a set in the same cycle wins)

module pc_return_stack #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_q,
  input  logic              call,
  input  logic              ret,
  input  logic              jump,
  input  logic [ADDR_W-1:0] target,
  output logic              load,
  output logic [ADDR_W-1:0] d,
  output logic [PTR_W:0]    depth,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              underflow,
  input  logic              flag_clr
);

  localparam logic [ADDR_W-1:0] ADDR_ZERO  = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0]  PTR_ZERO   = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0]  PTR_ONE    = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W:0]    DEPTH_ZERO = {(PTR_W+1){1'b0}};
  localparam logic [PTR_W:0]    DEPTH_ONE  = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W:0]    DEPTH_MAX  = (PTR_W+1)'(DEPTH);

  // Entry storage. top_r addresses the next free slot, so the live top entry
  // sits at top_r-1. When the stack is full, the next free slot is also the
  // oldest entry, which lets an overflowing push overwrite it in circular
  // fashion without extra logic.
  logic [ADDR_W-1:0] stack_r [DEPTH];
  logic [PTR_W-1:0]  top_r;
  logic [PTR_W:0]    depth_r;
  logic              overflow_r;
  logic              underflow_r;

  logic              do_ret_s;
  logic              do_call_s;
  logic              do_jump_s;
  logic              push_s;
  logic              pop_s;
  logic              set_ovf_s;
  logic              set_unf_s;
  logic              full_s;
  logic              empty_s;
  logic [ADDR_W-1:0] top_entry_s;
  logic [ADDR_W-1:0] ret_addr_s;
  logic              load_s;
  logic [ADDR_W-1:0] d_s;

  // Full and empty are decoded from the depth counter, never from the array.
  always_comb begin
    full_s  = (depth_r == DEPTH_MAX);
    empty_s = (depth_r == DEPTH_ZERO);
  end

  // Priority decode. Holding reset low discards any command in flight.
  always_comb begin
    do_ret_s  = 1'b0;
    do_call_s = 1'b0;
    do_jump_s = 1'b0;
    if (!reset) begin
      do_ret_s  = 1'b0;
      do_call_s = 1'b0;
      do_jump_s = 1'b0;
    end else if (ret) begin
      do_ret_s = 1'b1;
    end else if (call) begin
      do_call_s = 1'b1;
    end else if (jump) begin
      do_jump_s = 1'b1;
    end else begin
      do_ret_s  = 1'b0;
      do_call_s = 1'b0;
      do_jump_s = 1'b0;
    end
  end

  // Stack effects and sticky-flag set events for this cycle.
  always_comb begin
    push_s    = do_call_s;
    pop_s     = do_ret_s & ~empty_s;
    set_ovf_s = do_call_s & full_s;
    set_unf_s = do_ret_s & empty_s;
  end

  // Read the top entry and form the return address (it wraps modulo 2^ADDR_W).
  always_comb begin
    top_entry_s = stack_r[top_r - PTR_ONE];
    ret_addr_s  = pc_q + ADDR_ONE;
  end

  // PC load interface. It is combinational so that the PC loads on this edge.
  // A RET on an empty stack leaves load low, so the PC keeps incrementing.
  always_comb begin
    load_s = 1'b0;
    d_s    = ADDR_ZERO;
    if (pop_s) begin
      load_s = 1'b1;
      d_s    = top_entry_s;
    end else if (do_call_s || do_jump_s) begin
      load_s = 1'b1;
      d_s    = target;
    end else begin
      load_s = 1'b0;
      d_s    = ADDR_ZERO;
    end
  end

  // Entry array write. The contents do not matter after reset, so the array
  // has no reset of its own. push_s is already qualified by reset.
  always_ff @(posedge clock) begin
    if (push_s) begin
      stack_r[top_r] <= ret_addr_s;
    end
  end

  // Top pointer and depth counter. A push while full still advances the
  // pointer, but the depth stays saturated at DEPTH.
  always_ff @(posedge clock) begin
    if (!reset) begin
      top_r   <= PTR_ZERO;
      depth_r <= DEPTH_ZERO;
    end else if (push_s) begin
      top_r <= top_r + PTR_ONE;
      if (!full_s) begin
        depth_r <= depth_r + DEPTH_ONE;
      end
    end else if (pop_s) begin
      top_r   <= top_r - PTR_ONE;
      depth_r <= depth_r - DEPTH_ONE;
    end
  end

  // Sticky error flags. A set event takes precedence over flag_clr.
  always_ff @(posedge clock) begin
    if (!reset) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (set_ovf_s) begin
        overflow_r <= 1'b1;
      end else if (flag_clr) begin
        overflow_r <= 1'b0;
      end
      if (set_unf_s) begin
        underflow_r <= 1'b1;
      end else if (flag_clr) begin
        underflow_r <= 1'b0;
      end
    end
  end

  // Drive the outputs.
  always_comb begin
    load      = load_s;
    d         = d_s;
    depth     = depth_r;
    full      = full_s;
    empty     = empty_s;
    overflow  = overflow_r;
    underflow = underflow_r;
  end

endmodule

// File: tb/tb_pc_return_stack.sv
// tb_pc_return_stack
//
// Directed, table-driven bench for pc_return_stack (ADDR_W=12, DEPTH=4).
// Each vector drives one cycle of commands. load and d are checked before the
// edge, and depth, full, empty and the flags are checked after it. A short
// hand-written sequence follows the table. It takes the stack through a full
// round trip that crosses the pointer wrap.

module tb_pc_return_stack;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] pc_q = 12'h000;
  logic        call = 1'b0;
  logic        ret = 1'b0;
  logic        jump = 1'b0;
  logic [11:0] target = 12'h000;
  logic        flag_clr = 1'b0;
  logic        load;
  logic [11:0] d;
  logic [2:0]  depth;
  logic        full;
  logic        empty;
  logic        overflow;
  logic        underflow;

  int checks = 0;
  int failures = 0;

  pc_return_stack #(.ADDR_W(12), .DEPTH(4), .PTR_W(2)) dut (
    .clock(clock), .reset(reset), .pc_q(pc_q), .call(call), .ret(ret),
    .jump(jump), .target(target), .load(load), .d(d), .depth(depth),
    .full(full), .empty(empty), .overflow(overflow), .underflow(underflow),
    .flag_clr(flag_clr)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic        c;
    logic        r;
    logic        j;
    logic        clr;
    logic [11:0] pc;
    logic [11:0] tgt;
    logic        e_load;
    logic [11:0] e_d;
    logic [2:0]  e_depth;
    logic        e_full;
    logic        e_empty;
    logic        e_ovf;
    logic        e_unf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, c, r, j, clr, input logic [11:0] pc, tgt,
                     input logic e_load, input logic [11:0] e_d, input logic [2:0] e_depth,
                     input logic e_full, e_empty, e_ovf, e_unf);
    vec_t v;
    v = '{rst, c, r, j, clr, pc, tgt, e_load, e_d, e_depth, e_full, e_empty, e_ovf, e_unf};
    vecs.push_back(v);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    @(negedge clock);
    reset = v.rst; call = v.c; ret = v.r; jump = v.j; flag_clr = v.clr;
    pc_q = v.pc; target = v.tgt;
    #1;
    chk($sformatf("v%0d.load", idx), {31'd0, load}, {31'd0, v.e_load});
    chk($sformatf("v%0d.d", idx), {20'd0, d}, {20'd0, v.e_d});
    @(posedge clock);
    #1;
    chk($sformatf("v%0d.depth", idx), {29'd0, depth}, {29'd0, v.e_depth});
    chk($sformatf("v%0d.full", idx), {31'd0, full}, {31'd0, v.e_full});
    chk($sformatf("v%0d.empty", idx), {31'd0, empty}, {31'd0, v.e_empty});
    chk($sformatf("v%0d.ovf", idx), {31'd0, overflow}, {31'd0, v.e_ovf});
    chk($sformatf("v%0d.unf", idx), {31'd0, underflow}, {31'd0, v.e_unf});
  endtask

  initial begin
    logic [11:0] model[$];
    logic [11:0] exp_top;
    vec_t v;

    //   rst c r j clr  pc       tgt     load d       dep  full empty ovf unf
    add(0, 0,0,0,0, 12'h000, 12'h000, 0, 12'h000, 3'd0, 0, 1, 0, 0);   // reset
    add(1, 0,0,1,0, 12'h010, 12'h200, 1, 12'h200, 3'd0, 0, 1, 0, 0);   // jump
    add(1, 1,0,0,0, 12'h010, 12'h300, 1, 12'h300, 3'd1, 0, 0, 0, 0);   // call
    add(1, 0,1,0,0, 12'h300, 12'h000, 1, 12'h011, 3'd0, 0, 1, 0, 0);   // ret
    add(1, 1,0,0,0, 12'h100, 12'h400, 1, 12'h400, 3'd1, 0, 0, 0, 0);   // nested
    add(1, 1,0,0,0, 12'h200, 12'h500, 1, 12'h500, 3'd2, 0, 0, 0, 0);
    add(1, 1,0,0,0, 12'h300, 12'h600, 1, 12'h600, 3'd3, 0, 0, 0, 0);
    add(1, 0,1,0,0, 12'h600, 12'h000, 1, 12'h301, 3'd2, 0, 0, 0, 0);
    add(1, 0,1,0,0, 12'h302, 12'h000, 1, 12'h201, 3'd1, 0, 0, 0, 0);
    add(1, 0,1,0,0, 12'h202, 12'h000, 1, 12'h101, 3'd0, 0, 1, 0, 0);
    add(1, 1,0,0,0, 12'h001, 12'h0A0, 1, 12'h0A0, 3'd1, 0, 0, 0, 0);   // fill
    add(1, 1,0,0,0, 12'h002, 12'h0A0, 1, 12'h0A0, 3'd2, 0, 0, 0, 0);
    add(1, 1,0,0,0, 12'h003, 12'h0A0, 1, 12'h0A0, 3'd3, 0, 0, 0, 0);
    add(1, 1,0,0,0, 12'h004, 12'h0A0, 1, 12'h0A0, 3'd4, 1, 0, 0, 0);
    add(1, 1,0,0,0, 12'h005, 12'h0A0, 1, 12'h0A0, 3'd4, 1, 0, 1, 0);   // overflow
    add(1, 0,1,0,0, 12'h0A0, 12'h000, 1, 12'h006, 3'd3, 0, 0, 1, 0);
    add(1, 0,1,0,0, 12'h007, 12'h000, 1, 12'h005, 3'd2, 0, 0, 1, 0);
    add(1, 0,1,0,0, 12'h006, 12'h000, 1, 12'h004, 3'd1, 0, 0, 1, 0);
    add(1, 0,1,0,0, 12'h005, 12'h000, 1, 12'h003, 3'd0, 0, 1, 1, 0);
    add(1, 0,1,0,0, 12'h004, 12'h000, 0, 12'h000, 3'd0, 0, 1, 1, 1);   // underflow
    add(1, 0,0,0,1, 12'h005, 12'h000, 0, 12'h000, 3'd0, 0, 1, 0, 0);   // clear
    add(1, 1,0,0,0, 12'hFFF, 12'h123, 1, 12'h123, 3'd1, 0, 0, 0, 0);   // wrap
    add(1, 0,1,0,0, 12'h123, 12'h000, 1, 12'h000, 3'd0, 0, 1, 0, 0);
    add(1, 1,0,0,0, 12'h054, 12'h777, 1, 12'h777, 3'd1, 0, 0, 0, 0);   // top=055
    add(1, 1,1,0,0, 12'h777, 12'h888, 1, 12'h055, 3'd0, 0, 1, 0, 0);   // ret>call
    add(1, 0,1,0,0, 12'h056, 12'h000, 0, 12'h000, 3'd0, 0, 1, 0, 1);
    add(1, 1,0,0,0, 12'h020, 12'h222, 1, 12'h222, 3'd1, 0, 0, 0, 1);
    add(0, 1,0,0,0, 12'h030, 12'h333, 0, 12'h000, 3'd0, 0, 1, 0, 0);   // reset+call
    add(1, 1,0,0,0, 12'h010, 12'h0B0, 1, 12'h0B0, 3'd1, 0, 0, 0, 0);
    add(1, 1,0,0,0, 12'h011, 12'h0B0, 1, 12'h0B0, 3'd2, 0, 0, 0, 0);
    add(1, 1,0,0,0, 12'h012, 12'h0B0, 1, 12'h0B0, 3'd3, 0, 0, 0, 0);
    add(1, 1,0,0,0, 12'h013, 12'h0B0, 1, 12'h0B0, 3'd4, 1, 0, 0, 0);
    add(1, 1,0,0,1, 12'h014, 12'h0B0, 1, 12'h0B0, 3'd4, 1, 0, 1, 0);   // set wins
    add(1, 0,0,0,1, 12'h0B0, 12'h000, 0, 12'h000, 3'd4, 1, 0, 0, 0);   // clear
    add(1, 0,1,1,0, 12'h0B1, 12'h0CC, 1, 12'h015, 3'd3, 0, 0, 0, 0);   // ret>jump
    add(1, 1,0,1,0, 12'h016, 12'h0DD, 1, 12'h0DD, 3'd4, 1, 0, 0, 0);   // call>jump

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Round trip after the last table row. The stack now holds, from bottom
    // to top, 012, 013, 014 and 017, and top_r has wrapped. One more call
    // overflows and evicts 012. Four returns then unwind in LIFO order.
    model = '{12'h013, 12'h014, 12'h017};
    v = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h700, 12'h0E0,
          1'b1, 12'h0E0, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0};
    run_vec(v, 100);
    model.push_back(12'h701);
    for (int k = 0; k < 4; k++) begin
      exp_top = model.pop_back();
      v = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h0E0, 12'h000,
            1'b1, exp_top, 3'(model.size()), 1'b0, (model.size() == 0), 1'b1, 1'b0};
      run_vec(v, 101 + k);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
